// File: rtl/fetch_pcu.sv
// fetch_pcu: program counter and pipelined instruction-fetch sequencer.
// Keeps up to MAX_OUTSTANDING fetches in flight, remembers each request PC in a
// small FIFO, and silently drops responses that belong to fetches issued before
// a redirect.
// Optional feature macro: PCU_REDIRECT_BYPASS_EN -- issue the fetch for the
// redirect target in the redirect cycle itself.
module fetch_pcu #(
    parameter int unsigned     XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC        = XLEN'(32'h8000_0000),
    parameter int unsigned     INST_BYTES      = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_req_valid,
    input  logic            inst_req_ready,
    output logic [XLEN-1:0] inst_req_addr,
    input  logic            inst_resp_valid,
    output logic            inst_resp_ready,
    input  logic [XLEN-1:0] inst_resp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_inst
);

    localparam int unsigned     PTR_W      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned     CNT_W      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [XLEN-1:0] STRIDE     = XLEN'(INST_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(STRIDE - XLEN'(1));
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(MAX_OUTSTANDING - 1);

    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_queue [MAX_OUTSTANDING];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_drop_cnt;

    logic [XLEN-1:0]  w_redirect_pc_al;
    logic             w_drop_pending;
    logic             w_req_fire;
    logic             w_resp_fire;
    logic [CNT_W-1:0] w_cnt_after_pop;

    // Circular pointer advance; depth need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake decode, issue and delivery outputs.
    always_comb begin
        w_redirect_pc_al = redirect_pc & ALIGN_MASK;
        w_drop_pending   = (r_drop_cnt != '0);
        inst_resp_ready  = !rst && (w_drop_pending || redirect_valid || out_ready);
        w_resp_fire      = inst_resp_valid && inst_resp_ready;
        w_cnt_after_pop  = r_cnt - CNT_W'(w_resp_fire);
        out_valid        = !rst && inst_resp_valid && !w_drop_pending && !redirect_valid;
        out_pc           = r_queue[r_rd_ptr];
        out_inst         = inst_resp_data;
        inst_req_valid   = !rst && (r_cnt < CNT_MAX) && !redirect_valid;
        inst_req_addr    = r_pc;
`ifdef PCU_REDIRECT_BYPASS_EN
        // Fetch the redirect target at once; room is judged after this cycle's pop.
        if (redirect_valid) begin
            inst_req_valid = !rst && (w_cnt_after_pop < CNT_MAX);
            inst_req_addr  = w_redirect_pc_al;
        end
`endif
        w_req_fire = inst_req_valid && inst_req_ready;
    end

    // PC, occupancy, stale-response count and FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC & ALIGN_MASK;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_req_fire) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_resp_fire) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_cnt <= w_cnt_after_pop + CNT_W'(w_req_fire);
            if (redirect_valid) begin
                // Every request still in flight becomes stale; a same-cycle
                // bypass fetch is pushed behind them and stays live.
                r_drop_cnt <= w_cnt_after_pop;
                r_pc       <= w_req_fire ? (inst_req_addr + STRIDE) : w_redirect_pc_al;
            end else begin
                if (w_resp_fire && w_drop_pending) begin
                    r_drop_cnt <= r_drop_cnt - CNT_W'(1);
                end
                if (w_req_fire) begin
                    r_pc <= inst_req_addr + STRIDE;
                end
            end
        end
    end

    // Request PC storage; contents are only meaningful while counted in r_cnt.
    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            r_queue[r_wr_ptr] <= inst_req_addr;
        end
    end

endmodule

// File: tb/tb_fetch_pcu.sv
// Bench for fetch_pcu: in-order memory model with fixed latency, a scoreboard of
// expected delivered PCs filled by the stimulus, and a monitor that pops it.
module tb_fetch_pcu;

    localparam int LAT = 1;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_req_valid;
    logic        inst_req_ready;
    logic [31:0] inst_req_addr;
    logic        inst_resp_valid = 1'b0;
    logic        inst_resp_ready;
    logic [31:0] inst_resp_data  = 32'h0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    fetch_pcu #(
        .XLEN(32),
        .RESET_PC(32'h8000_0000),
        .INST_BYTES(4),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .inst_req_valid(inst_req_valid),
        .inst_req_ready(inst_req_ready),
        .inst_req_addr(inst_req_addr),
        .inst_resp_valid(inst_resp_valid),
        .inst_resp_ready(inst_resp_ready),
        .inst_resp_data(inst_resp_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc(out_pc),
        .out_inst(out_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    int          n_total = 0;
    int          n_bad   = 0;
    int          n_req   = 0;
    int          cyc     = 0;
    logic [31:0] exp_q[$];
    mreq_t       mq[$];
    logic [31:0] req_log[$];

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5A5A_00FF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    // Wait (bounded) until the monitor has consumed every expected delivery.
    task automatic wait_empty(input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            #3;
            if (exp_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            n_total++;
            n_bad++;
            $display("FAIL %s_timeout: %0d deliveries still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Hold out_ready low for 10 cycles and report how many requests were issued.
    task automatic stall10(output int nreq);
        int base;
        @(negedge clk);
        out_ready = 1'b0;
        base = n_req;
        repeat (9) @(negedge clk);
        #2;
        nreq = n_req - base;
    endtask

    // In-order memory: response available LAT cycles after the request handshake.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (mq.size() != 0 && mq[0].due <= cyc) begin
            inst_resp_valid = 1'b1;
            inst_resp_data  = inst_of(mq[0].addr);
        end else begin
            inst_resp_valid = 1'b0;
            inst_resp_data  = 32'h0;
        end
        #1;
        if (rst) begin
            mq.delete();
            inst_resp_valid = 1'b0;
            inst_resp_data  = 32'h0;
        end else begin
            if (inst_resp_valid && inst_resp_ready) void'(mq.pop_front());
            if (inst_req_valid && inst_req_ready) begin
                mq.push_back('{inst_req_addr, cyc + LAT});
                req_log.push_back(inst_req_addr);
                n_req++;
            end
        end
    end

    // Monitor: every delivery to ID must be the next expected PC and its word.
    always @(negedge clk) begin : mon
        logic [31:0] e;
        #2;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL out_unexpected: got pc %h, required no delivery", out_pc);
            end else begin
                e = exp_q.pop_front();
                chk("out_pc", out_pc, e);
                chk("out_inst", out_inst, inst_of(e));
            end
        end
    end

    initial begin : stim
        int nreq;
        int base_log;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_req_ready = 1'b1;
        out_ready      = 1'b1;

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk1("rst_req_valid", inst_req_valid, 1'b0);
            chk1("rst_resp_ready", inst_resp_ready, 1'b0);
            chk1("rst_out_valid", out_valid, 1'b0);
            if (i > 0) chk("rst_req_addr", inst_req_addr, 32'h8000_0000);
        end

        // Sequential stream, first request in the first cycle out of reset.
        push_seq(32'h8000_0000, 4);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk1("first_req_valid", inst_req_valid, 1'b1);
        chk("first_req_addr", inst_req_addr, 32'h8000_0000);
        @(negedge clk);
        #1;
        chk("req1_addr", inst_req_addr, 32'h8000_0004);
        chk1("stream_out_valid", out_valid, 1'b1);
        @(negedge clk);
        #1;
        chk("req2_addr", inst_req_addr, 32'h8000_0008);
        wait_empty("stream");

        // Backpressure: 0x80000010 and 0x80000014 end up outstanding.
        stall10(nreq);
        chk1("bp1_issue_bound", nreq <= 2, 1'b1);
        chk("bp1_outstanding", 32'(mq.size()), 32'd2);
        chk1("bp1_head_valid", out_valid, 1'b1);
        chk("bp1_head_pc", out_pc, 32'h8000_0010);

        // Redirect coinciding with the stalled response: both stale responses drop.
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        out_ready      = 1'b1;
        push_seq(32'h8000_0100, 4);
        #1;
        chk1("redir_resp_present", inst_resp_valid, 1'b1);
        chk1("redir_out_valid", out_valid, 1'b0);
        chk1("redir_resp_consumed", inst_resp_ready, 1'b1);
`ifdef PCU_REDIRECT_BYPASS_EN
        chk1("redir_byp_req_valid", inst_req_valid, 1'b1);
        chk("redir_byp_req_addr", inst_req_addr, 32'h8000_0100);
`else
        chk1("redir_req_valid", inst_req_valid, 1'b0);
`endif
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk1("stale2_present", inst_resp_valid, 1'b1);
        chk1("stale2_out_valid", out_valid, 1'b0);
        wait_empty("redirect1");

        // Second backpressure window, then release: no PC skipped or duplicated.
        stall10(nreq);
        chk1("bp2_issue_bound", nreq <= 2, 1'b1);
        chk("bp2_head_pc", out_pc, 32'h8000_0110);
        @(negedge clk);
        out_ready = 1'b1;
        push_seq(32'h8000_0110, 4);
        wait_empty("release");

        // Unaligned redirect target; low bits are cleared.
        stall10(nreq);
        chk("bp3_head_pc", out_pc, 32'h8000_0120);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0203;
        out_ready      = 1'b1;
        base_log       = req_log.size();
        push_seq(32'h8000_0200, 4);
        #1;
        chk1("redir2_out_valid", out_valid, 1'b0);
`ifdef PCU_REDIRECT_BYPASS_EN
        chk1("redir2_byp_req_valid", inst_req_valid, 1'b1);
        chk("redir2_byp_req_addr", inst_req_addr, 32'h8000_0200);
`else
        chk1("redir2_req_valid", inst_req_valid, 1'b0);
`endif
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_empty("redirect2");
        chk("redir2_first_req", (req_log.size() > base_log) ? req_log[base_log] : 32'hDEAD_BEEF,
            32'h8000_0200);
        chk("redir2_next_req", (req_log.size() > base_log + 1) ? req_log[base_log + 1] : 32'hDEAD_BEEF,
            32'h8000_0204);

        // Reset in the middle of traffic.
        @(negedge clk);
        out_ready = 1'b0;
        rst       = 1'b1;
        #1;
        chk1("mid_rst_req_valid", inst_req_valid, 1'b0);
        chk1("mid_rst_resp_ready", inst_resp_ready, 1'b0);
        chk1("mid_rst_out_valid", out_valid, 1'b0);
        @(negedge clk);
        #1;
        chk("mid_rst_req_addr", inst_req_addr, 32'h8000_0000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk1("post_rst_req_valid", inst_req_valid, 1'b1);
        chk("post_rst_req_addr", inst_req_addr, 32'h8000_0000);
        chk1("post_rst_out_valid", out_valid, 1'b0);
        @(negedge clk);
        #3;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at 200000, required finish");
        $fatal(1);
    end

endmodule
